// File: rtl/kid_bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kid_bullet_pkg
// Description : Shared types and constants for the kid bullet pool: slot state
//               encoding, default pool tuning and the visible screen bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package kid_bullet_pkg;

    // Per-slot lifecycle state
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } slot_state_t;

    // Default tuning of the bullet pool
    localparam int c_DEF_NUM_BULLETS  = 4;
    localparam int c_DEF_BULLET_SPEED = 8;
    localparam int c_DEF_COOLDOWN     = 10;
    localparam int c_DEF_BULLET_SIZE  = 4;
    localparam int c_DEF_BOSS_SIZE    = 64;

    // Visible screen bounds (last pixel column / row)
    localparam int c_SCREEN_X_MAX = 639;
    localparam int c_SCREEN_Y_MAX = 479;

    // Bullets spawn this far right/down from the kid's top-left corner
    localparam int c_LAUNCH_OFFSET = 16;

endpackage : kid_bullet_pkg
`default_nettype wire

// File: rtl/kid_bullet_if.sv
`default_nettype none
// ============================================================================
// Module      : kid_bullet_if
// Description : Frame-rate signal bundle between the game logic (master) and
//               the bullet pool (slave): fire control, positions, raster
//               position and the bullet render/hit results.
// Revision    : 1.0 - initial release
// ============================================================================
interface kid_bullet_if;
    logic        fire;
    logic        facing_left;
    logic [9:0]  Kid_position_X;
    logic [9:0]  Kid_position_Y;
    logic [9:0]  Boss_position_X;
    logic [9:0]  Boss_position_Y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        isBullet;
    logic [24:0] Bullet_address;
    logic        hitBoss;
    logic [2:0]  bullets_live;

    modport master (
        output fire, facing_left, Kid_position_X, Kid_position_Y,
               Boss_position_X, Boss_position_Y, DrawX, DrawY,
        input  isBullet, Bullet_address, hitBoss, bullets_live
    );

    modport slave (
        input  fire, facing_left, Kid_position_X, Kid_position_Y,
               Boss_position_X, Boss_position_Y, DrawX, DrawY,
        output isBullet, Bullet_address, hitBoss, bullets_live
    );
endinterface : kid_bullet_if
`default_nettype wire

// File: rtl/kid_bullet_slot.sv
`default_nettype none
// ============================================================================
// Module      : bullet_slot
// Description : One bullet of the pool. Holds position and direction, moves
//               every frame, retires at the screen edge or on a boss hit, and
//               reports whether the current raster pixel lies on it.
// Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot
    import kid_bullet_pkg::*;
#(
    parameter int BULLET_SPEED = c_DEF_BULLET_SPEED,
    parameter int BULLET_SIZE  = c_DEF_BULLET_SIZE,
    parameter int BOSS_SIZE    = c_DEF_BOSS_SIZE
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_launch,
    input  wire logic       i_launch_dir,
    input  wire logic [9:0] i_launch_x,
    input  wire logic [9:0] i_launch_y,
    input  wire logic [9:0] i_boss_x,
    input  wire logic [9:0] i_boss_y,
    input  wire logic [9:0] i_draw_x,
    input  wire logic [9:0] i_draw_y,
    output logic            o_flying,
    output logic            o_hit,
    output logic            o_on_pixel
);

    slot_state_t r_state, w_state_nxt;
    logic [9:0]  r_x, w_x_nxt;
    logic [9:0]  r_y, w_y_nxt;
    logic        r_dir, w_dir_nxt;   // 1 = moving left

    logic [10:0] w_x11, w_y11, w_bx11, w_by11, w_dx11, w_dy11;
    logic        w_hit, w_retire;

    // Widen to 11 bits so the +size offsets never wrap
    assign w_x11  = {1'b0, r_x};
    assign w_y11  = {1'b0, r_y};
    assign w_bx11 = {1'b0, i_boss_x};
    assign w_by11 = {1'b0, i_boss_y};
    assign w_dx11 = {1'b0, i_draw_x};
    assign w_dy11 = {1'b0, i_draw_y};

    assign w_hit = (r_state == FLYING)
                && (w_x11 + 11'(BULLET_SIZE) >= w_bx11)
                && (w_x11 <= w_bx11 + 11'(BOSS_SIZE - 1 + BULLET_SIZE))
                && (w_y11 + 11'(BULLET_SIZE) >= w_by11)
                && (w_y11 <= w_by11 + 11'(BOSS_SIZE - 1 + BULLET_SIZE));

    // Another step would leave the visible area (or wrap below zero)
    assign w_retire = r_dir ? (r_x < 10'(BULLET_SPEED))
                            : (r_x > 10'(c_SCREEN_X_MAX - BULLET_SPEED));

    // |DrawX-X| <= size expressed without subtraction
    assign o_on_pixel = (r_state == FLYING)
                     && (w_dx11 + 11'(BULLET_SIZE) >= w_x11)
                     && (w_dx11 <= w_x11 + 11'(BULLET_SIZE))
                     && (w_dy11 + 11'(BULLET_SIZE) >= w_y11)
                     && (w_dy11 <= w_y11 + 11'(BULLET_SIZE));

    assign o_flying = (r_state == FLYING);
    assign o_hit    = w_hit;

    // State and position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Launch, move, or retire; a hit wins over both movement and edge exit
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        case (r_state)
            IDLE: begin
                if (i_launch) begin
                    w_state_nxt = FLYING;
                    w_x_nxt     = i_launch_x;
                    w_y_nxt     = i_launch_y;
                    w_dir_nxt   = i_launch_dir;
                end
            end
            FLYING: begin
                if (w_hit || w_retire) begin
                    w_state_nxt = IDLE;
                end else if (r_dir) begin
                    w_x_nxt = r_x - 10'(BULLET_SPEED);
                end else begin
                    w_x_nxt = r_x + 10'(BULLET_SPEED);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule : bullet_slot
`default_nettype wire

// File: rtl/kid_bullet.sv
`default_nettype none
// ============================================================================
// Module      : kid_bullet
// Description : Pool of NUM_BULLETS kid bullets. Allocates the lowest free slot
//               on fire, enforces the launch cooldown, merges slot hits into a
//               single registered pulse and renders the bullets.
//               Build option KID_BULLET_FIRE_EDGE_EN: launch only on a rising
//               edge of fire instead of while fire is held.
// Revision    : 1.0 - initial release
// ============================================================================
module kid_bullet
    import kid_bullet_pkg::*;
#(
    parameter int NUM_BULLETS  = c_DEF_NUM_BULLETS,
    parameter int BULLET_SPEED = c_DEF_BULLET_SPEED,
    parameter int COOLDOWN     = c_DEF_COOLDOWN,
    parameter int BULLET_SIZE  = c_DEF_BULLET_SIZE,
    parameter int BOSS_SIZE    = c_DEF_BOSS_SIZE
) (
    input  wire logic   frame_clk,
    input  wire logic   Reset_h,
    kid_bullet_if.slave bus
);

    localparam int c_CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    logic [c_CD_W-1:0]      r_cooldown;
    logic                   r_hit_boss;
    logic                   w_fire_req;
    logic                   w_launch;
    logic                   w_found;
    logic [NUM_BULLETS-1:0] w_flying, w_hit, w_pix, w_launch_sel;
    logic [2:0]             w_live;
    logic [9:0]             w_launch_x, w_launch_y;

`ifdef KID_BULLET_FIRE_EDGE_EN
    logic r_fire_d;

    // Previous-frame copy of fire for rising-edge detection
    always_ff @(posedge frame_clk) begin
        if (Reset_h) r_fire_d <= 1'b0;
        else         r_fire_d <= bus.fire;
    end

    assign w_fire_req = bus.fire & ~r_fire_d;
`else
    assign w_fire_req = bus.fire;
`endif

    // A slot retiring this edge is still FLYING here, so it cannot be reused yet
    assign w_launch   = w_fire_req && (r_cooldown == '0) && (|(~w_flying));
    assign w_launch_x = bus.Kid_position_X + 10'(c_LAUNCH_OFFSET);
    assign w_launch_y = bus.Kid_position_Y + 10'(c_LAUNCH_OFFSET);

    // Select the lowest-index idle slot for a launch
    always_comb begin
        w_launch_sel = '0;
        w_found      = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (w_launch && !w_found && !w_flying[i]) begin
                w_launch_sel[i] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
            bullet_slot #(
                .BULLET_SPEED (BULLET_SPEED),
                .BULLET_SIZE  (BULLET_SIZE),
                .BOSS_SIZE    (BOSS_SIZE)
            ) u_slot (
                .clk          (frame_clk),
                .rst          (Reset_h),
                .i_launch     (w_launch_sel[gi]),
                .i_launch_dir (bus.facing_left),
                .i_launch_x   (w_launch_x),
                .i_launch_y   (w_launch_y),
                .i_boss_x     (bus.Boss_position_X),
                .i_boss_y     (bus.Boss_position_Y),
                .i_draw_x     (bus.DrawX),
                .i_draw_y     (bus.DrawY),
                .o_flying     (w_flying[gi]),
                .o_hit        (w_hit[gi]),
                .o_on_pixel   (w_pix[gi])
            );
        end
    endgenerate

    // Cooldown: reload on launch, otherwise count down to zero and hold
    always_ff @(posedge frame_clk) begin
        if (Reset_h)                r_cooldown <= '0;
        else if (w_launch)          r_cooldown <= c_CD_W'(COOLDOWN - 1);
        else if (r_cooldown != '0)  r_cooldown <= r_cooldown - c_CD_W'(1);
    end

    // One registered pulse no matter how many slots hit together
    always_ff @(posedge frame_clk) begin
        if (Reset_h) r_hit_boss <= 1'b0;
        else         r_hit_boss <= |w_hit;
    end

    // Count of slots currently flying
    always_comb begin
        w_live = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_live = w_live + 3'(w_flying[i]);
        end
    end

    assign bus.hitBoss        = r_hit_boss;
    assign bus.bullets_live   = w_live;
    assign bus.isBullet       = |w_pix;
    assign bus.Bullet_address = (|w_pix) ? 25'd1 : 25'd0;

endmodule : kid_bullet
`default_nettype wire
